// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding requests to
// instruction memory, buffers returned words and hands them to decode in order.

package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] instruction;
    logic        illegal;
  } instruction_t;

  typedef struct packed {
    logic         valid;
    logic         ready;
    logic [31:0]  pc;
    instruction_t instruction;
    logic         exception;
    logic [3:0]   cause;
  } stage_status_t;

endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump,
  input  logic [31:0]   pc_next,
  input  logic          stage_ready,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output stage_status_t stage_out
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {
    StFetch,
    StDiscard
  } state_e;

  state_e            state_q;
  logic [31:0]       fetch_pc_q;
  logic              pending_q;
  logic [31:0]       req_addr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [31:0]       pc_mem    [FIFO_DEPTH];
  logic [31:0]       instr_mem [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic launch;
  logic ack;
  logic push;
  logic unused_pc_bits;

  assign unused_pc_bits = ^pc_next[1:0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && stage_ready;

  // A new request needs a slot that is free once this cycle's pop has happened;
  // the slot then stays reserved by pending_q until the ack lands.
  assign launch   = (state_q == StFetch) && !pending_q && (!fifo_full || pop);
  assign mem_req  = !rst && (pending_q || launch);
  assign mem_addr = pending_q ? req_addr_q : fetch_pc_q;
  assign ack      = mem_req && mem_ack;

  // Wrong-path data (redirect this cycle or a request left over from a redirect) is dropped.
  assign push = ack && (state_q == StFetch) && !jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      pending_q  <= 1'b0;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pending_q <= mem_req && !mem_ack;
      if (launch) begin
        req_addr_q <= fetch_pc_q;
      end

      unique case (state_q)
        StFetch: begin
          if (jump && mem_req && !mem_ack) begin
            state_q <= StDiscard;
          end
        end
        StDiscard: begin
          if (ack) begin
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase

      if (jump) begin
        // The head is consumed by decode and everything behind it is wrong-path.
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        fetch_pc_q <= {pc_next[31:2], 2'b00};
      end else begin
        if (push) begin
          wr_ptr_q   <= wr_ptr_q + PtrW'(1);
          fetch_pc_q <= mem_addr + 32'd4;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
          count_q <= count_q + CntW'(1);
        end else if (!push && pop) begin
          count_q <= count_q - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= mem_addr;
      instr_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  always_comb begin
    stage_out       = '0;
    stage_out.ready = !rst;
    if (!rst && !fifo_empty) begin
      stage_out.valid                   = 1'b1;
      stage_out.pc                      = pc_mem[rd_ptr_q];
      stage_out.instruction.instruction = instr_mem[rd_ptr_q];
    end
  end

endmodule
